// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2).
//   clog2   : ceiling log2, used to size the slice counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
//   start, a, b, cin, sub : request side, driven by the master.
//   busy, done, s, cout, ovf : status/result side, driven by the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple-carry slice.
//   a, b  : slice operands
//   cin   : carry into the slice LSB
//   s     : slice sum
//   cout  : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for signed overflow on the last slice)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor.
//   clk, rst : clock and synchronous active-high reset
//   bus      : serial_adder_if slave (start/a/b/cin/sub in, busy/done/s/cout/ovf out)
// An accepted request takes WIDTH/DIGIT RUN cycles, LSB slice first; the
// result registers update only on the final slice and hold until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic [DIGIT-1:0] sl_s;
  logic             sl_cout;
  logic             sl_cmsb;
  logic             accept;

  assign accept = (state != RUN) && bus.start;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // Slice sums enter at the top and drift down, so after N slices the
  // first (LSB) slice sits at bit 0.
  assign acc_next = (acc >> DIGIT) | (WIDTH'(sl_s) << (WIDTH - DIGIT));

  // Operand shifters and partial-result accumulator (no reset needed: fully
  // reloaded on accept and fully shifted through before use).
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b ^ {WIDTH{bus.sub}};
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      acc  <= acc_next;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      s_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + ~borrow_in.
            carry  <= bus.cin ^ bus.sub;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= sl_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            s_r    <= acc_next;
            cout_r <= sl_cout;
            ovf_r  <= sl_cmsb ^ sl_cout;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (W8/D1, W8/D4, W4/D2) checked
// against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus0 ();
  serial_adder_if #(.WIDTH(8)) bus1 ();
  serial_adder_if #(.WIDTH(4)) bus2 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_adder #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int u);
    return (u == 2) ? 4 : 8;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer arithmetic on the specification's rules.
  function automatic void model(input int w, input int a, input int b, input int ci,
                                input int sb, output int s, output int co, output int ov);
    int r, sa, sbv, sr, half, full;
    half = 1 << (w - 1);
    full = 1 << w;
    r    = sb ? (a - b - ci) : (a + b + ci);
    s    = r & (full - 1);
    co   = sb ? int'(r >= 0) : int'(r >= full);
    sa   = (a >= half) ? a - full : a;
    sbv  = (b >= half) ? b - full : b;
    sr   = sb ? (sa - sbv - ci) : (sa + sbv + ci);
    ov   = int'(sr >= half || sr < -half);
  endfunction

  task automatic drv(input int u, input logic st, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb);
    case (u)
      0: begin bus0.start = st; bus0.a = a; bus0.b = b; bus0.cin = ci; bus0.sub = sb; end
      1: begin bus1.start = st; bus1.a = a; bus1.b = b; bus1.cin = ci; bus1.sub = sb; end
      default: begin
        bus2.start = st; bus2.a = a[3:0]; bus2.b = b[3:0]; bus2.cin = ci; bus2.sub = sb;
      end
    endcase
  endtask

  task automatic rd(input int u, output logic bsy, output logic dn, output logic [7:0] s,
                    output logic co, output logic ov);
    case (u)
      0: begin bsy = bus0.busy; dn = bus0.done; s = bus0.s; co = bus0.cout; ov = bus0.ovf; end
      1: begin bsy = bus1.busy; dn = bus1.done; s = bus1.s; co = bus1.cout; ov = bus1.ovf; end
      default: begin
        bsy = bus2.busy; dn = bus2.done; s = {4'h0, bus2.s}; co = bus2.cout; ov = bus2.ovf;
      end
    endcase
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation from an idle/done instance; operand inputs are scrambled
  // while it runs, and the result must not move until completion.
  task automatic do_op(input int u, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb, input string tag);
    logic bsy, dn, co, ov;
    logic [7:0] s, s_prev;
    int es, eco, eov, cyc;
    rd(u, bsy, dn, s_prev, co, ov);
    drv(u, 1'b1, a, b, ci, sb);
    tick();
    rd(u, bsy, dn, s, co, ov);
    chk({tag, ".busy"}, 32'(bsy), 32'd1);
    chk({tag, ".done0"}, 32'(dn), 32'd0);
    cyc = 0;
    dn  = 1'b0;
    while (!dn && cyc < 40) begin
      drv(u, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      cyc++;
      rd(u, bsy, dn, s, co, ov);
      if (!dn) chk({tag, ".hold"}, 32'(s), 32'(s_prev));
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(lat_of(u)));
    model(width_of(u), int'(a) & ((1 << width_of(u)) - 1), int'(b) & ((1 << width_of(u)) - 1),
          int'(ci), int'(sb), es, eco, eov);
    chk({tag, ".s"}, 32'(s), es);
    chk({tag, ".cout"}, 32'(co), eco);
    chk({tag, ".ovf"}, 32'(ov), eov);
    chk({tag, ".busyd"}, 32'(bsy), 32'd0);
    tick();
    rd(u, bsy, dn, s, co, ov);
    chk({tag, ".pulse"}, 32'(dn), 32'd0);
    chk({tag, ".idle"}, 32'(bsy), 32'd0);
    chk({tag, ".keep"}, 32'(s), es);
  endtask

  task automatic kchk(input int u, input int es, input int eco, input int eov, input string tag);
    logic bsy, dn, co, ov;
    logic [7:0] s;
    rd(u, bsy, dn, s, co, ov);
    chk({tag, ".ks"}, 32'(s), es);
    chk({tag, ".kcout"}, 32'(co), eco);
    chk({tag, ".kovf"}, 32'(ov), eov);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bsy, dn, co, ov;
    logic [7:0] s;
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic       oc [4];
    logic       os [4];
    int es, eco, eov, cyc, ndone;

    rst = 1'b1;
    for (int u = 0; u < 3; u++) drv(u, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    for (int u = 0; u < 3; u++) begin
      rd(u, bsy, dn, s, co, ov);
      chk("rst.busy", 32'(bsy), 32'd0);
      chk("rst.done", 32'(dn), 32'd0);
      chk("rst.s", 32'(s), 32'd0);
      chk("rst.cout", 32'(co), 32'd0);
      chk("rst.ovf", 32'(ov), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Directed cases with hand-derived results.
    do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
    kchk(0, 'h00, 1, 0, "ff_plus_1");
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "7f_plus_1");
    kchk(0, 'h80, 0, 1, "7f_plus_1");
    do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, "5_minus_7");
    kchk(0, 'hFE, 0, 0, "5_minus_7");
    do_op(1, 8'h3C, 8'hC4, 1'b1, 1'b0, "d4_add");
    kchk(1, 'h01, 1, 0, "d4_add");

    // start pulsed mid-RUN with zero operands must be ignored.
    drv(0, 1'b1, 8'h5A, 8'h33, 1'b0, 1'b0);
    tick();
    cyc = 0;
    dn  = 1'b0;
    while (!dn && cyc < 40) begin
      if (cyc == 2) drv(0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      else drv(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      cyc++;
      rd(0, bsy, dn, s, co, ov);
    end
    chk("midstart.lat", 32'(cyc), 32'd8);
    chk("midstart.s", 32'(s), 32'h8D);
    chk("midstart.cout", 32'(co), 32'd0);
    chk("midstart.ovf", 32'(ov), 32'd1);
    tick();
    rd(0, bsy, dn, s, co, ov);
    chk("midstart.nodone", 32'(dn), 32'd0);

    // start held high: back-to-back operations, one done each, no idle gap.
    for (int i = 0; i < 4; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    drv(1, 1'b1, oa[0], ob[0], oc[0], os[0]);
    tick();
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      dn  = 1'b0;
      while (!dn && cyc < 20) begin
        tick();
        cyc++;
        rd(1, bsy, dn, s, co, ov);
      end
      chk("b2b.gap", 32'(cyc), (i == 0) ? 32'd2 : 32'd3);
      model(8, int'(oa[i]), int'(ob[i]), int'(oc[i]), int'(os[i]), es, eco, eov);
      chk("b2b.s", 32'(s), es);
      chk("b2b.cout", 32'(co), eco);
      chk("b2b.ovf", 32'(ov), eov);
      if (i < 3) drv(1, 1'b1, oa[i+1], ob[i+1], oc[i+1], os[i+1]);
      else drv(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    tick();
    rd(1, bsy, dn, s, co, ov);
    chk("b2b.end", 32'(dn), 32'd0);

    // Reset in the middle of a run aborts it.
    drv(0, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    drv(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(0, bsy, dn, s, co, ov);
    chk("abort.busy", 32'(bsy), 32'd0);
    chk("abort.done", 32'(dn), 32'd0);
    chk("abort.s", 32'(s), 32'd0);
    chk("abort.cout", 32'(co), 32'd0);
    chk("abort.ovf", 32'(ov), 32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      rd(0, bsy, dn, s, co, ov);
      if (dn) ndone++;
    end
    chk("abort.nodone", 32'(ndone), 32'd0);
    do_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, "after_abort");

    // Randomized operations on the 8-bit instances.
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), "rand");
    end

    // Exhaustive sweep on the 4-bit instance.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++)
            do_op(2, 8'(ia), 8'(ib), 1'(ic), 1'(is), "exh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
